// File: rtl/a2d_pkg.sv
// Shared types and constants for the IR-sensor A2D interface.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package a2d_pkg;

    localparam int SCLK_DIV_DEF  = 32;
    localparam int FRNT_PRCH_DEF = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TX1  = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_TX2  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0]  CMD_PFX = 2'b00;
    localparam logic [10:0] CMD_PAD = 11'h000;

    function automatic logic [15:0] build_cmd(input logic [2:0] ch);
        return {CMD_PFX, ch, CMD_PAD};
    endfunction

endpackage

// File: rtl/a2d_intf_if.sv
// Bundle of the control handshake and the SPI pins of the A2D interface.
// Latency: n/a (wiring only).
// Backpressure: n/a; strt_cnv is dropped by the master while busy.
interface a2d_intf_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  strt_cnv, chnnl, MISO,
        output cnv_cmplt, res, SS_n, SCLK, MOSI
    );

    modport slave (
        output strt_cnv, chnnl, MISO,
        input  cnv_cmplt, res, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/a2d_intf_spi_mstr16.sv
// SPI mode-3 16-bit master: slave select, divided SCLK and one shared shift register.
// Latency: SS_n rises FRNT_PRCH + 16*SCLK_DIV clk after wrt; done pulses the cycle before.
// Backpressure: wrt is ignored while a transaction is in flight.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV  = SCLK_DIV_DEF,
    parameter int FRNT_PRCH = FRNT_PRCH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int CNT_W = $clog2(SCLK_DIV);
    localparam logic [CNT_W-1:0] CNT_PRESET = CNT_W'(SCLK_DIV - FRNT_PRCH);
    localparam logic [CNT_W-1:0] CNT_RISE   = CNT_W'(SCLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FALL   = CNT_W'(SCLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [4:0]       rise_cnt;
    logic [15:0]      shft;
    logic             ss_n_q;
    logic             mosi_q;
    logic             last;

    // After the 16th rise, the wrap that would be fall 17 ends the frame instead.
    assign last    = (rise_cnt == 5'd16) && (div_cnt == CNT_FALL);
    assign done    = ~ss_n_q & last;
    assign rd_data = shft;
    assign SS_n    = ss_n_q;
    assign SCLK    = div_cnt[CNT_W-1];
    assign MOSI    = mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q   <= 1'b1;
            div_cnt  <= CNT_PRESET;
            rise_cnt <= 5'd0;
            shft     <= 16'h0000;
            mosi_q   <= 1'b0;
        end else if (ss_n_q) begin
            if (wrt) begin
                ss_n_q   <= 1'b0;
                div_cnt  <= CNT_PRESET;
                rise_cnt <= 5'd0;
                shft     <= cmd;
            end
        end else if (last) begin
            ss_n_q  <= 1'b1;
            div_cnt <= CNT_PRESET;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
            if (div_cnt == CNT_FALL) begin
                mosi_q <= shft[15];
                shft   <= {shft[14:0], 1'b0};
            end
            if (div_cnt == CNT_RISE) begin
                shft[0]  <= MISO;
                rise_cnt <= rise_cnt + 5'd1;
            end
        end
    end

endmodule

// File: rtl/a2d_intf.sv
// A2D conversion sequencer: channel-select frame, gap, result frame; A2D_OVRSMPL_EN averages 4 pairs.
// Latency: fixed, two SPI frames plus one gap clk (four pairs when oversampling) from strt_cnv.
// Backpressure: strt_cnv is ignored in any state other than IDLE.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV  = SCLK_DIV_DEF,
    parameter int FRNT_PRCH = FRNT_PRCH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    a2d_intf_if.master    bus
);

    logic [2:0]  state;
    logic [2:0]  chnnl_q;
    logic [11:0] res_q;
    logic        cmplt_q;
    logic        wrt;
    logic        done;
    logic [15:0] cmd;
    logic [15:0] rd_data;
    logic        unused_hi;

    // The first frame must carry chnnl in the same cycle it is accepted.
    assign wrt = ((state == ST_IDLE) && bus.strt_cnv) || (state == ST_GAP);
    assign cmd = build_cmd((state == ST_IDLE) ? bus.chnnl : chnnl_q);
    assign unused_hi = ^rd_data[15:12];

    assign bus.res       = res_q;
    assign bus.cnv_cmplt = cmplt_q;

`ifdef A2D_OVRSMPL_EN
    logic [13:0] acc;
    logic [13:0] acc_sum;
    logic [1:0]  pair_cnt;
    logic        nxt_tx1;

    assign acc_sum = acc + {2'b00, rd_data[11:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            chnnl_q <= 3'd0;
            res_q   <= 12'h000;
            cmplt_q <= 1'b0;
`ifdef A2D_OVRSMPL_EN
            acc      <= 14'd0;
            pair_cnt <= 2'd0;
            nxt_tx1  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.strt_cnv) begin
                        state   <= ST_TX1;
                        chnnl_q <= bus.chnnl;
                        cmplt_q <= 1'b0;
`ifdef A2D_OVRSMPL_EN
                        acc      <= 14'd0;
                        pair_cnt <= 2'd0;
                        nxt_tx1  <= 1'b0;
`endif
                    end
                end
                ST_TX1: begin
                    if (done) state <= ST_GAP;
                end
                ST_GAP: begin
`ifdef A2D_OVRSMPL_EN
                    state   <= nxt_tx1 ? ST_TX1 : ST_TX2;
                    nxt_tx1 <= 1'b0;
`else
                    state <= ST_TX2;
`endif
                end
                ST_TX2: begin
                    if (done) begin
`ifdef A2D_OVRSMPL_EN
                        if (pair_cnt == 2'd3) begin
                            res_q   <= acc_sum[13:2];
                            cmplt_q <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            acc      <= acc_sum;
                            pair_cnt <= pair_cnt + 2'd1;
                            nxt_tx1  <= 1'b1;
                            state    <= ST_GAP;
                        end
`else
                        res_q   <= rd_data[11:0];
                        cmplt_q <= 1'b1;
                        state   <= ST_DONE;
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    spi_mstr16 #(
        .SCLK_DIV  (SCLK_DIV),
        .FRNT_PRCH (FRNT_PRCH)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (bus.SS_n),
        .SCLK    (bus.SCLK),
        .MOSI    (bus.MOSI),
        .MISO    (bus.MISO)
    );

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: an A2D slave model on the SPI pins, table-driven and random conversions.
// Honours A2D_OVRSMPL_EN (four frame pairs per conversion, averaged result).
module tb_a2d_intf;
    import a2d_pkg::*;

`ifdef A2D_OVRSMPL_EN
    localparam int NPAIR = 4;
`else
    localparam int NPAIR = 1;
`endif
    localparam int TCLK = 10;

    logic clk;
    logic rst_n;

    a2d_intf_if bus ();

    a2d_intf #(
        .SCLK_DIV  (SCLK_DIV_DEF),
        .FRNT_PRCH (FRNT_PRCH_DEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int first_lat = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- A2D slave model ----------------
    typedef struct {
        logic [15:0] mosi;
        int          falls;
        longint      fp;
        longint      tail;
    } txn_t;

    txn_t        txn_q[$];
    logic [15:0] ret_q[$];
    longint      gap_q[$];
    logic [15:0] rword = 16'h0000;
    logic [15:0] mosi_w = 16'h0000;
    int          fidx = 0;
    longint      fp_cur = -1;
    time         t_ssf = 0;
    time         t_ssr = 0;
    time         t_lrise = 0;
    bit          have_rise = 1'b0;
    int          sclk_edges = 0;
    int          bad_edges = 0;

    always @(negedge bus.SS_n) begin
        if (ret_q.size() > 0) rword = ret_q.pop_front();
        else rword = 16'h0000;
        fidx   = 0;
        mosi_w = 16'h0000;
        fp_cur = -1;
        t_ssf  = $time;
        if (have_rise) gap_q.push_back(longint'($time - t_ssr));
    end

    always @(negedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            if (fidx == 0) fp_cur = longint'($time - t_ssf);
            bus.MISO = (fidx < 16) ? rword[15 - fidx] : 1'b0;
            fidx++;
        end
    end

    always @(posedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            mosi_w  = {mosi_w[14:0], bus.MOSI};
            t_lrise = $time;
        end
    end

    always @(posedge bus.SS_n) begin
        txn_q.push_back('{mosi_w, fidx, fp_cur, longint'($time - t_lrise)});
        t_ssr     = $time;
        have_rise = 1'b1;
    end

    always @(bus.SCLK) begin
        if ($time > 0 && rst_n === 1'b1) begin
            sclk_edges++;
            if (bus.SS_n === 1'b1) bad_edges++;
        end
    end

    // ---------------- one conversion, fully checked ----------------
    task automatic run_conv(input logic [2:0] ch, input logic [15:0] rets [4],
                            input logic [11:0] exp_res, input logic [15:0] exp_cmd,
                            input int poke_at, input string tag);
        int lat;
        int tot;
        bit ok;
        txn_q.delete();
        ret_q.delete();
        gap_q.delete();
        for (int p = 0; p < NPAIR; p++) begin
            ret_q.push_back(16'($urandom));
            ret_q.push_back(rets[p]);
        end
        @(negedge clk);
        bus.strt_cnv = 1'b1;
        bus.chnnl    = ch;
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        bus.chnnl    = 3'($urandom);
        chk({tag, "_cmplt_clr"}, 32'(bus.cnv_cmplt), 32'd0);
        lat = 1;
        ok  = 1'b0;
        for (int c = 0; c < 6000 && !ok; c++) begin
            if (c == poke_at) begin
                bus.strt_cnv = 1'b1;
                bus.chnnl    = 3'd7;
            end else begin
                bus.strt_cnv = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (bus.cnv_cmplt === 1'b1) ok = 1'b1;
        end
        bus.strt_cnv = 1'b0;
        chk({tag, "_done"}, 32'(ok), 32'd1);
        if (first_lat < 0) first_lat = lat;
        else chk({tag, "_latency"}, 32'(lat), 32'(first_lat));
        chk({tag, "_res"}, 32'(bus.res), 32'(exp_res));
        chk({tag, "_ntxn"}, 32'(txn_q.size()), 32'(2 * NPAIR));
        tot = 0;
        foreach (txn_q[i]) begin
            tot += txn_q[i].falls;
            chk({tag, "_mosi"}, 32'(txn_q[i].mosi), 32'(exp_cmd));
            chk({tag, "_frnt_prch"}, 32'(txn_q[i].fp), 32'(FRNT_PRCH_DEF * TCLK));
            chk({tag, "_ss_tail"}, 32'(txn_q[i].tail), 32'(SCLK_DIV_DEF / 2 * TCLK));
        end
        chk({tag, "_falls"}, 32'(tot), 32'(16 * 2 * NPAIR));
        chk({tag, "_ngap"}, 32'(gap_q.size() >= 2 * NPAIR - 1), 32'd1);
        for (int k = 1; k <= 2 * NPAIR - 1; k++)
            if (k <= gap_q.size())
                chk({tag, "_gap"}, 32'(gap_q[gap_q.size() - k]), 32'(TCLK));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  ch;
        logic [15:0] ret;
        logic [11:0] exp_res;
        logic [15:0] exp_cmd;
        int          poke;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] r4 [4];
        logic [2:0]  ch;
        int          sum;
        logic [11:0] exp_r;
        bit          hit;

        vecs[0] = '{3'd4, 16'h0ABC, 12'hABC, 16'h2000, -1};
        vecs[1] = '{3'd1, 16'h5101, 12'h101, 16'h0800, -1};
        vecs[2] = '{3'd0, 16'hA100, 12'h100, 16'h0000, -1};
        vecs[3] = '{3'd4, 16'h0104, 12'h104, 16'h2000, -1};
        vecs[4] = '{3'd2, 16'hF102, 12'h102, 16'h1000, -1};
        vecs[5] = '{3'd3, 16'h3103, 12'h103, 16'h1800, -1};
        vecs[6] = '{3'd7, 16'h8107, 12'h107, 16'h3800, -1};
        vecs[7] = '{3'd2, 16'h0777, 12'h777, 16'h1000, 100};

        rst_n        = 1'b0;
        bus.strt_cnv = 1'b0;
        bus.chnnl    = 3'd0;
        bus.MISO     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (1000) @(negedge clk);
        chk("idle_ss_n", 32'(bus.SS_n), 32'd1);
        chk("idle_sclk", 32'(bus.SCLK), 32'd1);
        chk("idle_mosi", 32'(bus.MOSI), 32'd0);
        chk("idle_cmplt", 32'(bus.cnv_cmplt), 32'd0);
        chk("idle_res", 32'(bus.res), 32'd0);
        chk("idle_sclk_edges", 32'(sclk_edges), 32'd0);

        // Back-to-back table; last row pokes strt_cnv(ch7) mid-TX1
        for (int i = 0; i < 8; i++) begin
            r4 = '{vecs[i].ret, vecs[i].ret, vecs[i].ret, vecs[i].ret};
            run_conv(vecs[i].ch, r4, vecs[i].exp_res, vecs[i].exp_cmd, vecs[i].poke,
                     $sformatf("vec%0d", i));
        end
        repeat (40) @(negedge clk);
        chk("held_cmplt", 32'(bus.cnv_cmplt), 32'd1);
        chk("held_res", 32'(bus.res), 32'h777);
        chk("held_ntxn", 32'(txn_q.size()), 32'(2 * NPAIR));
        chk("held_ss_n", 32'(bus.SS_n), 32'd1);

        // strt_cnv during the DONE cycle is dropped
        r4 = '{16'h0042, 16'h0042, 16'h0042, 16'h0042};
        run_conv(3'd1, r4, 12'h042, 16'h0800, -1, "pre_done");
        bus.strt_cnv = 1'b1;
        bus.chnnl    = 3'd5;
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        repeat (5) @(negedge clk);
        chk("done_poke_ss_n", 32'(bus.SS_n), 32'd1);
        chk("done_poke_cmplt", 32'(bus.cnv_cmplt), 32'd1);
        chk("done_poke_ntxn", 32'(txn_q.size()), 32'(2 * NPAIR));

        // Random conversions against the arithmetic model
        for (int r = 0; r < 6; r++) begin
            ch  = 3'($urandom);
            sum = 0;
            for (int p = 0; p < 4; p++) r4[p] = 16'($urandom);
            for (int p = 0; p < NPAIR; p++) sum += int'(r4[p][11:0]);
            exp_r = (NPAIR == 4) ? 12'(sum / 4) : 12'(sum);
            repeat ($urandom_range(0, 15)) @(negedge clk);
            run_conv(ch, r4, exp_r, 16'(ch) << 11, -1, $sformatf("rnd%0d", r));
        end

        // Reset in the 10th SCLK period of TX2
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn_q.delete();
        ret_q.delete();
        for (int p = 0; p < NPAIR; p++) begin
            ret_q.push_back(16'hFFFF);
            ret_q.push_back(16'hFFFF);
        end
        @(negedge clk);
        bus.strt_cnv = 1'b1;
        bus.chnnl    = 3'd6;
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            if (txn_q.size() == 1 && bus.SS_n === 1'b0 && fidx >= 10) hit = 1'b1;
        end
        chk("rst_reach_tx2", 32'(hit), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ss_n", 32'(bus.SS_n), 32'd1);
        chk("rst_sclk", 32'(bus.SCLK), 32'd1);
        chk("rst_mosi", 32'(bus.MOSI), 32'd0);
        chk("rst_cmplt", 32'(bus.cnv_cmplt), 32'd0);
        chk("rst_res", 32'(bus.res), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_ss_n", 32'(bus.SS_n), 32'd1);
        chk("post_rst_res", 32'(bus.res), 32'd0);
        r4 = '{16'h0123, 16'h0123, 16'h0123, 16'h0123};
        run_conv(3'd5, r4, 12'h123, 16'h2800, -1, "fresh");

`ifdef A2D_OVRSMPL_EN
        r4 = '{16'h0100, 16'h0101, 16'h0102, 16'h0105};
        run_conv(3'd3, r4, 12'h102, 16'h1800, -1, "ovrsmpl");
        repeat (40) @(negedge clk);
        chk("ovrsmpl_one_cmplt", 32'(txn_q.size()), 32'd8);
`endif

        chk("no_sclk_while_ss_high", 32'(bad_edges), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
